data_mem_ctrl: RTL and testbench

- Load/store stage directly downstream of the single-cycle datapath. It consumes ALUOut as the address and WriteData as the store data, and returns read data to the datapath's Data input.
- Bridges the core to a multi-cycle memory over a valid/ready request channel and a valid-only response channel.
- Asserts Stall to freeze the PC and register writes until the access completes.
- Detects misaligned word accesses and memory timeouts.

---
 rtl/data_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - load/store stage bridging the core to a multi-cycle memory
//
// Ports:
//   CLK, rst                 clock (rising edge), asynchronous active-high reset
//   MemRead, MemWrite        load/store request from the control unit
//   Addr, WData              byte address (ALUOut) and store data (WriteData)
//   RData                    load data back to the datapath
//   Stall                    freezes PC / register writes while high
//   MisalignErr              access with Addr[1:0] != 0 (no request issued)
//   TimeoutErr               one-cycle pulse when an access is aborted
//   mem_req_*                registered valid/ready request channel (word aligned)
//   mem_resp_valid/rdata     valid-only read response channel, sampled in WAIT only
module data_mem_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [ADDRESS_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0]    WData,
  output logic [DATA_WIDTH-1:0]    RData,
  output logic                     Stall,
  output logic                     MisalignErr,
  output logic                     TimeoutErr,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0]    mem_req_wdata,
  input  logic                     mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]    mem_resp_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    timeout_q;
  logic                    access;
  logic                    busy;
  logic                    expire;
  logic                    complete;
  logic                    abort;

  assign access      = (MemRead | MemWrite) && (Addr[1:0] == 2'b00);
  assign MisalignErr = (MemRead | MemWrite) && (Addr[1:0] != 2'b00);
  assign busy        = (state == REQ) || (state == WAIT);
  assign Stall       = ((state == IDLE) && access) || busy;
  // A misaligned access shows zero on the data path for that cycle only;
  // the last loaded value is still held underneath.
  assign RData       = MisalignErr ? '0 : rdata_q;
  assign TimeoutErr  = timeout_q;

  // Completion on the expiry cycle takes priority over the abort.
  // A read accepted on the expiry cycle has not completed, so it aborts.
  assign expire   = busy && (cnt == CNT_LAST);
  assign complete = ((state == REQ) && mem_req_ready && mem_req_we) ||
                    ((state == WAIT) && mem_resp_valid);
  assign abort    = expire && !complete;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (access) state_next = REQ;
      REQ: begin
        if (abort)              state_next = DONE;
        else if (mem_req_ready) state_next = mem_req_we ? DONE : WAIT;
      end
      WAIT: if (complete || abort) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      rdata_q       <= '0;
      timeout_q     <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
    end else begin
      timeout_q <= abort;
      case (state)
        IDLE: begin
          if (access) begin
            cnt           <= '0;
            mem_req_valid <= 1'b1;
            mem_req_we    <= MemWrite;
            mem_req_addr  <= {Addr[ADDRESS_WIDTH-1:2], 2'b00};
            mem_req_wdata <= WData;
          end
        end
        REQ: begin
          cnt <= cnt + CW'(1);
          if (mem_req_ready || abort) mem_req_valid <= 1'b0;
          if (abort) rdata_q <= '0;
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (mem_resp_valid) rdata_q <= mem_resp_rdata;
          else if (abort)     rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;
  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [31:0] Addr, WData, RData;
  logic        Stall, MisalignErr, TimeoutErr;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_rdata;
  logic [31:0] mem_model [16];

  int          r_stall, r_valid, r_first, r_bad, r_terr, r_done;
  logic [31:0] r_rdata;

  data_mem_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Addr(Addr), .WData(WData),
    .RData(RData), .Stall(Stall), .MisalignErr(MisalignErr), .TimeoutErr(TimeoutErr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Plays one instruction plus the memory side: request accepted after acc_dly
  // extra REQ cycles, response rsp_dly cycles after the first WAIT cycle.
  // Returns observations only; the calling tests compare them.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input int acc_dly, input int rsp_dly,
                           input logic [31:0] rsp_data);
    int  wcnt;
    bit  accepted;
    r_stall = 0; r_valid = 0; r_first = -1; r_bad = 0; r_terr = 0; r_done = 0;
    r_rdata = '0; wcnt = 0; accepted = 0;
    for (int cyc = 0; cyc < 40 && r_done == 0; cyc++) begin
      @(negedge CLK);
      MemRead = rd; MemWrite = wr; Addr = a; WData = wd;
      mem_req_ready  = mem_req_valid && (r_valid == acc_dly);
      mem_resp_valid = accepted && (wcnt == rsp_dly);
      mem_resp_rdata = mem_resp_valid ? rsp_data : $urandom;
      #1;
      if (mem_req_valid) begin
        if (r_first < 0) r_first = cyc;
        r_valid++;
        if (mem_req_we !== wr || mem_req_addr !== {a[31:2], 2'b00} ||
            (wr && mem_req_wdata !== wd)) r_bad++;
      end
      if (TimeoutErr === 1'b1) r_terr++;
      if (accepted) wcnt++;
      if (mem_req_valid && mem_req_ready) accepted = 1;
      if (Stall === 1'b1) r_stall++;
      else begin
        r_done  = 1;
        r_rdata = RData;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      MemRead = 0; MemWrite = 0; mem_req_ready = 0;
      mem_resp_valid = 1'($urandom_range(0, 1)); mem_resp_rdata = $urandom;
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1; MemRead = 0; MemWrite = 0; Addr = 0; WData = 0;
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'hA5A5A5A5;
    repeat (2) @(negedge CLK);
    #1;
    n_checks++; if (RData !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", RData); end
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", Stall); end
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", mem_req_valid); end
    n_checks++; if (mem_req_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_req_we); end
    n_checks++; if (mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_req_addr); end
    n_checks++; if (mem_req_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", mem_req_wdata); end
    n_checks++; if (TimeoutErr !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %b want 0", TimeoutErr); end
    @(negedge CLK);
    rst = 0; mem_resp_valid = 0;
    last_rdata = 0;
    idle(2);
    n_checks++; if (RData !== 32'h0) begin n_fail++; $display("FAIL idle_resp_ignored: got %h want 0", RData); end
  endtask

  task automatic test_load_zero_wait;
    do_access(1, 0, 32'h10, 32'h0, 0, 0, 32'hCAFEF00D);
    n_checks++; if (r_done != 1) begin n_fail++; $display("FAIL load_done: got %0d want 1", r_done); end
    n_checks++; if (r_stall != 3) begin n_fail++; $display("FAIL load_stall: got %0d want 3", r_stall); end
    n_checks++; if (r_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL load_rdata: got %h want cafef00d", r_rdata); end
    n_checks++; if (r_bad != 0) begin n_fail++; $display("FAIL load_req_fields: got %0d bad cycles want 0", r_bad); end
    n_checks++; if (mem_req_addr !== 32'h10) begin n_fail++; $display("FAIL load_addr: got %h want 10", mem_req_addr); end
    last_rdata = 32'hCAFEF00D;
  endtask

  task automatic test_store_backpressure;
    do_access(0, 1, 32'h20, 32'h12345678, 4, 0, 32'h0);
    n_checks++; if (r_stall != 6) begin n_fail++; $display("FAIL store_stall: got %0d want 6", r_stall); end
    n_checks++; if (r_valid != 5) begin n_fail++; $display("FAIL store_valid_cycles: got %0d want 5", r_valid); end
    n_checks++; if (r_bad != 0) begin n_fail++; $display("FAIL store_req_fields: got %0d bad cycles want 0", r_bad); end
    n_checks++; if (r_rdata !== last_rdata) begin n_fail++; $display("FAIL store_rdata_kept: got %h want %h", r_rdata, last_rdata); end
  endtask

  task automatic test_misaligned;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      MemRead = 1; MemWrite = 0; Addr = 32'h13; mem_req_ready = 1; mem_resp_valid = 0;
      #1;
      n_checks++; if (MisalignErr !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b want 1", MisalignErr); end
      n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall: got %b want 0", Stall); end
      n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid: got %b want 0", mem_req_valid); end
      n_checks++; if (RData !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h want 0", RData); end
    end
    idle(1);
    n_checks++; if (MisalignErr !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", MisalignErr); end
    n_checks++; if (RData !== last_rdata) begin n_fail++; $display("FAIL mis_rdata_kept: got %h want %h", RData, last_rdata); end
  endtask

  task automatic test_simultaneous;
    do_access(1, 1, 32'h24, 32'h0BADF00D, 0, 0, 32'h11111111);
    n_checks++; if (r_stall != 2) begin n_fail++; $display("FAIL both_stall: got %0d want 2", r_stall); end
    n_checks++; if (r_bad != 0) begin n_fail++; $display("FAIL both_req_fields: got %0d bad cycles want 0", r_bad); end
    n_checks++; if (mem_req_we !== 1'b1) begin n_fail++; $display("FAIL both_we: got %b want 1", mem_req_we); end
    n_checks++; if (r_rdata !== last_rdata) begin n_fail++; $display("FAIL both_rdata_kept: got %h want %h", r_rdata, last_rdata); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    for (int k = 0; k < 2; k++) begin
      d = $urandom;
      do_access(1, 0, 32'h30 + 32'(k * 4), 32'h0, 0, 0, d);
      n_checks++; if (r_first != 1) begin n_fail++; $display("FAIL b2b_first_req: got cycle %0d want 1", r_first); end
      n_checks++; if (r_stall != 3) begin n_fail++; $display("FAIL b2b_stall: got %0d want 3", r_stall); end
      n_checks++; if (r_rdata !== d) begin n_fail++; $display("FAIL b2b_rdata: got %h want %h", r_rdata, d); end
      last_rdata = d;
    end
  endtask

  task automatic test_timeout;
    int          cnt_after;
    int          acc;
    logic [31:0] d;
    do_access(1, 0, 32'h40, 32'h0, 0, 1000, 32'h0);
    n_checks++; if (r_stall != 1 + TO) begin n_fail++; $display("FAIL to_rd_stall: got %0d want %0d", r_stall, 1 + TO); end
    n_checks++; if (r_terr != 1) begin n_fail++; $display("FAIL to_rd_terr: got %0d want 1", r_terr); end
    n_checks++; if (r_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rd_rdata: got %h want 0", r_rdata); end
    n_checks++; if (r_valid != 1) begin n_fail++; $display("FAIL to_rd_valid: got %0d want 1", r_valid); end
    last_rdata = 0;
    cnt_after = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (TimeoutErr === 1'b1) cnt_after++;
    end
    n_checks++; if (cnt_after != 0) begin n_fail++; $display("FAIL to_single_pulse: got %0d extra want 0", cnt_after); end

    d = $urandom | 32'h1;
    do_access(1, 0, 32'h44, 32'h0, 1, 1, d);
    n_checks++; if (r_rdata !== d) begin n_fail++; $display("FAIL to_recover_load: got %h want %h", r_rdata, d); end
    do_access(0, 1, 32'h48, 32'h55AA55AA, 1000, 0, 32'h0);
    n_checks++; if (r_stall != 1 + TO) begin n_fail++; $display("FAIL to_wr_stall: got %0d want %0d", r_stall, 1 + TO); end
    n_checks++; if (r_valid != TO) begin n_fail++; $display("FAIL to_wr_valid: got %0d want %0d", r_valid, TO); end
    n_checks++; if (r_terr != 1) begin n_fail++; $display("FAIL to_wr_terr: got %0d want 1", r_terr); end
    n_checks++; if (r_rdata !== 32'h0) begin n_fail++; $display("FAIL to_wr_rdata: got %h want 0", r_rdata); end

    // Completion landing exactly on the last allowed cycle is not a timeout.
    acc = $urandom_range(0, 3);
    d = $urandom;
    do_access(1, 0, 32'h4C, 32'h0, acc, TO - 2 - acc, d);
    n_checks++; if (r_stall != 1 + TO) begin n_fail++; $display("FAIL edge_stall: got %0d want %0d", r_stall, 1 + TO); end
    n_checks++; if (r_terr != 0) begin n_fail++; $display("FAIL edge_terr: got %0d want 0", r_terr); end
    n_checks++; if (r_rdata !== d) begin n_fail++; $display("FAIL edge_rdata: got %h want %h", r_rdata, d); end
    last_rdata = d;
    idle(1);
  endtask

  task automatic test_reset_mid_access;
    @(negedge CLK);
    MemRead = 1; MemWrite = 0; Addr = 32'h50; mem_req_ready = 0; mem_resp_valid = 0;
    @(negedge CLK);
    mem_req_ready = mem_req_valid;
    @(negedge CLK);
    mem_req_ready = 0;
    #1;
    n_checks++; if (Stall !== 1'b1 || mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pre_wait: got stall=%b valid=%b want 1/0", Stall, mem_req_valid); end
    #1;
    MemRead = 0; rst = 1;
    #1;
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", Stall); end
    n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", mem_req_valid); end
    n_checks++; if (RData !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", RData); end
    @(negedge CLK);
    rst = 0;
    last_rdata = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      mem_resp_valid = 1; mem_resp_rdata = 32'hDEADBEEF;
      #1;
      n_checks++; if (RData !== 32'h0) begin n_fail++; $display("FAIL late_resp_rdata: got %h want 0", RData); end
      n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL late_resp_stall: got %b want 0", Stall); end
    end
    idle(1);
  endtask

  task automatic test_random;
    int          op, idx, acc, rsp, exp_stall;
    logic [31:0] a, wd, exp_rd;
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    for (int it = 0; it < 40; it++) begin
      op  = $urandom_range(0, 2);
      idx = $urandom_range(0, 15);
      a   = 32'h100 + 32'(idx * 4);
      wd  = $urandom;
      acc = $urandom_range(0, 3);
      rsp = $urandom_range(0, 2);
      do_access(op != 1, op != 0, a, wd, acc, rsp, mem_model[idx]);
      if (op == 0) begin
        exp_stall = 3 + acc + rsp;
        exp_rd = mem_model[idx];
        last_rdata = exp_rd;
      end else begin
        exp_stall = 2 + acc;
        exp_rd = last_rdata;
        mem_model[idx] = wd;
      end
      n_checks++; if (r_stall != exp_stall) begin n_fail++; $display("FAIL rand_stall it=%0d: got %0d want %0d", it, r_stall, exp_stall); end
      n_checks++; if (r_valid != acc + 1) begin n_fail++; $display("FAIL rand_valid it=%0d: got %0d want %0d", it, r_valid, acc + 1); end
      n_checks++; if (r_first != 1) begin n_fail++; $display("FAIL rand_first it=%0d: got %0d want 1", it, r_first); end
      n_checks++; if (r_bad != 0) begin n_fail++; $display("FAIL rand_req_fields it=%0d: got %0d want 0", it, r_bad); end
      n_checks++; if (r_terr != 0) begin n_fail++; $display("FAIL rand_terr it=%0d: got %0d want 0", it, r_terr); end
      n_checks++; if (r_rdata !== exp_rd) begin n_fail++; $display("FAIL rand_rdata it=%0d: got %h want %h", it, r_rdata, exp_rd); end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
  endtask

  initial begin
    test_reset;
    test_load_zero_wait;
    test_store_backpressure;
    test_misaligned;
    test_simultaneous;
    test_back_to_back;
    test_timeout;
    test_reset_mid_access;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
